// File: rtl/rx_pkg.sv
// rx_pkg: shared state encoding and default sizing for the receive unstuff/deserialise stage
package rx_pkg;
    typedef enum logic {ACCEPT, STUFF} rx_state_e;
    localparam int RX_DATA_WIDTH = 8;
    localparam int RX_ONES_LIMIT = 6;
    localparam logic [7:0] SYNC_BYTE = 8'h80;
endpackage

// File: rtl/rx_unstuff_deser_if.sv
// rx_unstuff_deser_if: bit-stream input and byte/error output bundle of the unstuff/deserialise stage
interface rx_unstuff_deser_if
    import rx_pkg::*;
#(
    parameter int DATA_WIDTH = RX_DATA_WIDTH
);
    logic                  d_orig;
    logic                  shift_enable;
    logic                  eop;
    logic                  clear;
    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  byte_valid;
    logic                  stuff_err;
    logic                  align_err;

    modport master (
        output d_orig, shift_enable, eop, clear,
        input  rx_byte, byte_valid, stuff_err, align_err
    );

    modport slave (
        input  d_orig, shift_enable, eop, clear,
        output rx_byte, byte_valid, stuff_err, align_err
    );
endinterface

// File: rtl/rx_shift_reg.sv
// rx_shift_reg: serial-in right-shift register; exposes the value it is about to hold
module rx_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             din,
    output logic [WIDTH-1:0] pdata_next
);
    logic [WIDTH-1:0] sr_q, sr_d;

    assign pdata_next = {din, sr_q[WIDTH-1:1]};

    always_comb begin
        sr_d = clr ? '0 : shift_en ? pdata_next : sr_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) sr_q <= '0;
        else        sr_q <= sr_d;
    end
endmodule

// File: rtl/rx_unstuff_deser.sv
// rx_unstuff_deser: drops USB stuff bits and assembles LSB-first bytes with sticky error flags
module rx_unstuff_deser
    import rx_pkg::*;
#(
    parameter int DATA_WIDTH = RX_DATA_WIDTH,
    parameter int ONES_LIMIT = RX_ONES_LIMIT
) (
    input  logic              clk,
    input  logic              n_rst,
    rx_unstuff_deser_if.slave bus
);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int OW = $clog2(ONES_LIMIT + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [OW-1:0] LAST_ONE = OW'(ONES_LIMIT - 1);

    rx_state_e             state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [OW-1:0]         ones_cnt_q, ones_cnt_d;
    logic [DATA_WIDTH-1:0] rx_byte_q, rx_byte_d;
    logic                  byte_valid_q, byte_valid_d;
    logic                  stuff_err_q, stuff_err_d;
    logic                  align_err_q, align_err_d;
    logic                  sr_shift, sr_clr;
    logic [DATA_WIDTH-1:0] sr_next;

    rx_shift_reg #(.WIDTH(DATA_WIDTH)) u_sr (
        .clk        (clk),
        .n_rst      (n_rst),
        .shift_en   (sr_shift),
        .clr        (sr_clr),
        .din        (bus.d_orig),
        .pdata_next (sr_next)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_d = 1'b0;
        stuff_err_d  = stuff_err_q;
        align_err_d  = align_err_q;
        sr_shift     = 1'b0;
        sr_clr       = 1'b0;
        // clear outranks any bit on the same cycle, so a completing byte is lost too
        if (bus.clear) begin
            sr_clr      = 1'b1;
            state_d     = ACCEPT;
            bit_cnt_d   = '0;
            ones_cnt_d  = '0;
            stuff_err_d = 1'b0;
            align_err_d = 1'b0;
        end else if (bus.shift_enable && bus.eop) begin
            sr_clr      = 1'b1;
            state_d     = ACCEPT;
            bit_cnt_d   = '0;
            ones_cnt_d  = '0;
            align_err_d = align_err_q | (bit_cnt_q != '0);
        end else if (bus.shift_enable && state_q == STUFF) begin
            state_d     = ACCEPT;
            ones_cnt_d  = '0;
            stuff_err_d = stuff_err_q | bus.d_orig;
        end else if (bus.shift_enable) begin
            sr_shift     = 1'b1;
            ones_cnt_d   = bus.d_orig ? ones_cnt_q + 1'b1 : '0;
            state_d      = (bus.d_orig && ones_cnt_q == LAST_ONE) ? STUFF : ACCEPT;
            bit_cnt_d    = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
            byte_valid_d = (bit_cnt_q == LAST_BIT);
            rx_byte_d    = (bit_cnt_q == LAST_BIT) ? sr_next : rx_byte_q;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ACCEPT;
            bit_cnt_q    <= '0;
            ones_cnt_q   <= '0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            stuff_err_q  <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            rx_byte_q    <= rx_byte_d;
            byte_valid_q <= byte_valid_d;
            stuff_err_q  <= stuff_err_d;
            align_err_q  <= align_err_d;
        end
    end

    assign bus.rx_byte    = rx_byte_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.stuff_err  = stuff_err_q;
    assign bus.align_err  = align_err_q;
endmodule

// File: tb/tb_rx_unstuff_deser.sv
// tb_rx_unstuff_deser: strobe-by-strobe vector table with a byte scoreboard and an async-reset sequence
module tb_rx_unstuff_deser;
    import rx_pkg::*;

    localparam int GAP = 8;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    rx_unstuff_deser_if bus ();
    rx_unstuff_deser dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    typedef struct packed {
        logic       d;
        logic       eop;
        logic       clr;
        logic       bv;
        logic [7:0] rx;
        logic       serr;
        logic       aerr;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         n_vec = 0;
    int         n_err = 0;

    function automatic vec_t mk(input logic d, e, c, bv, input logic [7:0] rx, input logic s, a);
        mk = {d, e, c, bv, rx, s, a};
    endfunction

    task automatic add(input logic d, e, c, bv, input logic [7:0] rx, input logic s, a);
        vecs.push_back(mk(d, e, c, bv, rx, s, a));
    endtask

    task automatic add_bits(input logic [7:0] bits, input int n, input logic [7:0] rx, input logic s, a);
        for (int i = 0; i < n; i++) add(bits[i], 1'b0, 1'b0, 1'b0, rx, s, a);
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(posedge clk); #1;
        bus.d_orig       = v.d;
        bus.eop          = v.eop;
        bus.clear        = v.clr;
        bus.shift_enable = 1'b1;
        if (v.bv) sb.push_back(v.rx);
        @(posedge clk); #1;
        bus.d_orig       = 1'b0;
        bus.eop          = 1'b0;
        bus.clear        = 1'b0;
        bus.shift_enable = 1'b0;
        chk("byte_valid", idx, 8'(bus.byte_valid), 8'(v.bv));
        chk("rx_byte", idx, bus.rx_byte, v.rx);
        chk("stuff_err", idx, 8'(bus.stuff_err), 8'(v.serr));
        chk("align_err", idx, 8'(bus.align_err), 8'(v.aerr));
        repeat (GAP - 2) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (n_rst && bus.byte_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_byte: got byte_valid with %h expected no byte", bus.rx_byte);
            end else begin
                chk("sb_byte", n_vec, bus.rx_byte, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.d_orig = 1'b0;
        bus.eop = 1'b0;
        bus.clear = 1'b0;
        bus.shift_enable = 1'b0;

        add_bits(8'h00, 7, 8'h00, 1'b0, 1'b0);
        add(1, 0, 0, 1, SYNC_BYTE, 0, 0);
        add(1, 0, 1, 0, 8'h80, 0, 0);
        add_bits(8'b1011_1111, 8, 8'h80, 1'b0, 1'b0);
        add(1, 0, 0, 1, 8'hFF, 0, 0);
        add_bits(8'b0111_1110, 7, 8'hFF, 1'b0, 1'b0);
        add(1, 0, 0, 0, 8'hFF, 1, 0);
        add(1, 0, 0, 1, 8'hFE, 1, 0);
        add_bits(8'h00, 7, 8'hFE, 1'b1, 1'b0);
        add(1, 0, 0, 1, 8'h80, 1, 0);
        add(0, 0, 1, 0, 8'h80, 0, 0);
        add_bits(8'b0000_0101, 3, 8'h80, 1'b0, 1'b0);
        add(0, 1, 0, 0, 8'h80, 0, 1);
        add_bits(8'h00, 7, 8'h80, 1'b0, 1'b1);
        add(1, 0, 0, 1, 8'h80, 0, 1);
        add(0, 0, 1, 0, 8'h80, 0, 0);
        add_bits(8'b0101_0101, 7, 8'h80, 1'b0, 1'b0);
        add(0, 0, 0, 1, 8'h55, 0, 0);
        add(0, 1, 0, 0, 8'h55, 0, 0);
        add_bits(8'h00, 7, 8'h55, 1'b0, 1'b0);
        add(1, 0, 1, 0, 8'h55, 0, 0);
        add_bits(8'h00, 7, 8'h55, 1'b0, 1'b0);
        add(1, 0, 0, 1, 8'h80, 0, 0);

        #3;
        chk("reset_rx_byte", 0, bus.rx_byte, 8'h00);
        chk("reset_byte_valid", 0, 8'(bus.byte_valid), 8'h00);
        chk("reset_stuff_err", 0, 8'(bus.stuff_err), 8'h00);
        chk("reset_align_err", 0, 8'(bus.align_err), 8'h00);
        #10 n_rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // seven ones leave stuff_err set and a partial byte pending before the async reset
        apply(mk(0, 0, 1, 0, 8'h80, 0, 0), 1000);
        for (int i = 0; i < 6; i++) apply(mk(1, 0, 0, 0, 8'h80, 0, 0), 1001 + i);
        apply(mk(1, 0, 0, 0, 8'h80, 1, 0), 1007);
        #2 n_rst = 1'b0;
        #1;
        chk("async_rx_byte", 1008, bus.rx_byte, 8'h00);
        chk("async_byte_valid", 1008, 8'(bus.byte_valid), 8'h00);
        chk("async_stuff_err", 1008, 8'(bus.stuff_err), 8'h00);
        chk("async_align_err", 1008, 8'(bus.align_err), 8'h00);
        #2 n_rst = 1'b1;
        for (int i = 0; i < 7; i++) apply(mk(0, 0, 0, 0, 8'h00, 0, 0), 1010 + i);
        apply(mk(1, 0, 0, 1, 8'h80, 0, 0), 1017);

        repeat (4) @(posedge clk);
        chk("sb_empty", 0, 8'(sb.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
